// File: rtl/garage_pkg.sv
// garage_pkg: shared state encoding and default parameters for the garage door controller.
`default_nettype none

package garage_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    MV_UP = 2'b01,
    MV_DN = 2'b10
  } state_t;

  localparam int MOVE_TIMEOUT_DEF = 4096;
  localparam int CNT_W_DEF        = 12;

endpackage

`default_nettype wire

// File: rtl/garage_move_timer.sv
// garage_move_timer: clearable saturating move watchdog; timeout is high once the count reaches TIMEOUT-1.
`default_nettype none

module garage_move_timer
  import garage_pkg::*;
#(
  parameter int TIMEOUT = MOVE_TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic timeout
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Saturating at LIMIT keeps the timeout asserted rather than wrapping back to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count != LIMIT) begin
      count <= count + CNT_W'(1);
    end
  end

  assign timeout = (count == LIMIT);

endmodule

`default_nettype wire

// File: rtl/garage_door_ctrl.sv
// garage_door_ctrl: Moore FSM driving mutually exclusive up/down motor enables with a travel watchdog.
`default_nettype none

module garage_door_ctrl
  import garage_pkg::*;
#(
  parameter int MOVE_TIMEOUT = MOVE_TIMEOUT_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic activate,
  input  logic up_max,
  input  logic dn_max,
  output logic up_m,
  output logic dn_m
);

  state_t state;
  state_t next_state;
  logic   timeout;

  // Every move starts from IDLE, so clearing while idle also clears on each move entry.
  garage_move_timer #(
    .TIMEOUT (MOVE_TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_move_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == IDLE),
    .timeout (timeout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    up_m       = 1'b0;
    dn_m       = 1'b0;
    case (state)
      IDLE: begin
        if (activate && up_max && !dn_max) begin
          next_state = MV_DN;
        end else if (activate && dn_max && !up_max) begin
          next_state = MV_UP;
        end
      end
      MV_UP: begin
        up_m = 1'b1;
        if (up_max || timeout) begin
          next_state = IDLE;
        end
      end
      MV_DN: begin
        dn_m = 1'b1;
        if (dn_max || timeout) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_garage_door_ctrl.sv
// tb_garage_door_ctrl: directed self-checking bench for garage_door_ctrl with an 8-cycle watchdog.
`default_nettype none

module tb_garage_door_ctrl;

  logic clk;
  logic rst;
  logic activate;
  logic up_max;
  logic dn_max;
  logic up_m;
  logic dn_m;

  int n_checks = 0;
  int n_fail   = 0;

  garage_door_ctrl #(
    .MOVE_TIMEOUT (8),
    .CNT_W        (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .activate (activate),
    .up_max   (up_max),
    .dn_max   (dn_max),
    .up_m     (up_m),
    .dn_m     (dn_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares {up_m, dn_m} against the expected pair.
  task automatic check(input string tag, input logic [1:0] exp);
    logic [1:0] obs;
    obs = {up_m, dn_m};
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed up_m/dn_m=%b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "bench time limit expired");
  end

  initial begin
    rst = 1'b0; activate = 1'b0; up_max = 1'b0; dn_max = 1'b0;
    #3;
    check("reset_async", 2'b00);
    step();
    rst = 1'b1;
    check("reset_release", 2'b00);
    step();
    check("idle_no_input", 2'b00);

    // open -> closing
    activate = 1'b1; up_max = 1'b1; dn_max = 1'b0;
    step();
    check("open_to_dn", 2'b01);
    step();
    check("dn_hold_up_max", 2'b01);

    // closed limit reached -> idle -> opening
    up_max = 1'b0; dn_max = 1'b1;
    step();
    check("dn_limit_idle", 2'b00);
    step();
    check("closed_to_up", 2'b10);
    step();
    check("up_ignores_dn_max", 2'b10);

    // open limit reached -> idle -> closing
    up_max = 1'b1; dn_max = 1'b0;
    step();
    check("up_limit_idle", 2'b00);
    step();
    check("opened_to_dn", 2'b01);

    activate = 1'b0; up_max = 1'b0; dn_max = 1'b1;
    step();
    check("dn_stop_no_act", 2'b00);
    step();
    check("idle_stays_no_act", 2'b00);

    // unknown position: no motion
    activate = 1'b1; up_max = 1'b0; dn_max = 1'b0;
    step();
    check("unknown_pos_idle", 2'b00);

    // sensor fault: both limits high
    up_max = 1'b1; dn_max = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("sensor_fault_idle", 2'b00);
    end

    // watchdog: motor on for exactly 8 cycles
    up_max = 1'b1; dn_max = 1'b0;
    step();
    check("wd_start_dn", 2'b01);
    activate = 1'b0; up_max = 1'b0;
    for (int i = 2; i <= 8; i++) begin
      step();
      check("wd_dn_running", 2'b01);
    end
    step();
    check("wd_expired", 2'b00);
    step();
    check("wd_idle_after", 2'b00);
    step();
    check("wd_idle_after2", 2'b00);

    // asynchronous reset mid-move
    activate = 1'b1; dn_max = 1'b1; up_max = 1'b0;
    step();
    check("async_pre_up", 2'b10);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_mid_up", 2'b00);
    activate = 1'b0;
    step();
    check("rst_held", 2'b00);
    rst = 1'b1;
    step();
    check("post_rst_idle", 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
